// File: rtl/mem_copy_pkg.sv
// Shared definitions for the word-granular block-copy engine.
// Holds the FSM state encoding and the memory geometry constants.
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int MEM_ADR_W  = 12;

endpackage

// File: rtl/mem_copy_engine.sv
// Memory-port master that copies len words from src to dst, one read then one write per word,
// keeping a running modulo-2^32 checksum of every word it moves.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_adr,
  input  logic [31:0]      dst_adr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      checksum,
  output logic [31:0]      adr,
  output logic [31:0]      wr_data,
  output logic             MemRead,
  output logic             MemWrite,
  input  logic [31:0]      rd_data
);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_buf;
  logic [31:0]      r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (len == '0) ? DONE : READ;
      READ:    w_next = WRITE;
      WRITE:   w_next = (r_cnt == LEN_W'(1)) ? DONE : READ;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Working registers: arguments are latched once on acceptance, so later input changes are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_checksum <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_src      <= src_adr;
            r_dst      <= dst_adr;
            r_cnt      <= len;
            r_checksum <= '0;
          end
        end
        READ: begin
          r_buf      <= rd_data;
          r_checksum <= r_checksum + rd_data;
        end
        WRITE: begin
          r_src <= r_src + 32'(WORD_BYTES);
          r_dst <= r_dst + 32'(WORD_BYTES);
          r_cnt <= r_cnt - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Moore decodes: the address and data buses are forced to zero unless their enable is high.
  assign busy     = (r_state == READ) || (r_state == WRITE);
  assign done     = (r_state == DONE);
  assign MemRead  = (r_state == READ);
  assign MemWrite = (r_state == WRITE);
  assign adr      = (r_state == READ)  ? r_src :
                    (r_state == WRITE) ? r_dst : '0;
  assign wr_data  = (r_state == WRITE) ? r_buf : '0;
  assign checksum = r_checksum;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a byte-wide big-endian memory and a write scoreboard.
// A behavioural forward-copy model predicts every memory write and the final checksum.
module tb_mem_copy_engine;
  import mem_copy_pkg::*;

  localparam int MEM_BYTES = 1 << MEM_ADR_W;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_adr = '0;
  logic [31:0] dst_adr = '0;
  logic [10:0] len = '0;
  logic        busy;
  logic        done;
  logic [31:0] checksum;
  logic [31:0] adr;
  logic [31:0] wr_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] rd_data;

  logic [7:0]  mem   [MEM_BYTES];
  logic [7:0]  model [MEM_BYTES];
  logic        bdEn = 1'b0;
  logic [31:0] bdAdr = '0;
  logic [31:0] bdData = '0;

  wr_t expQ[$];
  wr_t actQ[$];
  int  total = 0;
  int  bad = 0;
  int  doneCount = 0;
  int  accessCount = 0;
  int  bothCount = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.LEN_W(11)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_adr  (src_adr),
    .dst_adr  (dst_adr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .adr      (adr),
    .wr_data  (wr_data),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .rd_data  (rd_data)
  );

  function automatic logic [31:0] memWord(input logic [11:0] a);
    return {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]};
  endfunction

  function automatic logic [31:0] modelWord(input logic [11:0] a);
    return {model[a], model[a + 12'd1], model[a + 12'd2], model[a + 12'd3]};
  endfunction

  always_comb rd_data = MemRead ? memWord(adr[11:0]) : '0;

  // Data memory: writes on the rising edge; the backdoor port preloads contents between copies.
  always @(posedge clk) begin
    if (MemWrite) begin
      for (int k = 0; k < 4; k++) mem[adr[11:0] + 12'(k)] <= wr_data[8*(3-k) +: 8];
      actQ.push_back('{adr, wr_data});
    end else if (bdEn) begin
      for (int k = 0; k < 4; k++) mem[bdAdr[11:0] + 12'(k)] <= bdData[8*(3-k) +: 8];
    end
  end

  always @(negedge clk) begin
    if (done) doneCount++;
    if (MemRead || MemWrite) accessCount++;
    if (MemRead && MemWrite) bothCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelWrite(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) model[a[11:0] + 12'(k)] = d[8*(3-k) +: 8];
  endtask

  task automatic pokeWord(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bdEn = 1'b1; bdAdr = a; bdData = d;
    @(negedge clk);
    bdEn = 1'b0;
    modelWrite(a, d);
  endtask

  // Forward word-by-word copy on the model; reading after writing reproduces overlap propagation.
  task automatic modelCopy(input logic [31:0] src, input logic [31:0] dst, input int n,
                           output logic [31:0] sum);
    logic [31:0] w;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      w = modelWord(12'(src + 32'(4*i)));
      sum = sum + w;
      modelWrite(dst + 32'(4*i), w);
      expQ.push_back('{dst + 32'(4*i), w});
    end
  endtask

  // Start is presented for one edge; the arguments are then scrambled to prove they were latched.
  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input logic [10:0] n);
    @(negedge clk);
    start = 1'b1; src_adr = src; dst_adr = dst; len = n;
    @(negedge clk);
    start = 1'b0; src_adr = 32'hBAD0_0F00; dst_adr = 32'hBAD0_0E00; len = 11'd5;
  endtask

  task automatic waitDone(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic checkWrites(input string tag);
    wr_t e, a;
    checkOutput($sformatf("%s_wrcount", tag), 32'(actQ.size()), 32'(expQ.size()));
    while (expQ.size() > 0 && actQ.size() > 0) begin
      e = expQ.pop_front();
      a = actQ.pop_front();
      checkOutput($sformatf("%s_wradr", tag), a.a, e.a);
      checkOutput($sformatf("%s_wrdata", tag), a.d, e.d);
    end
    expQ.delete();
    actQ.delete();
  endtask

  initial begin
    int          cyc;
    int          acc0;
    int          done0;
    logic [31:0] expSum;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_memread", 32'(MemRead), 32'd0);
    checkOutput("rst_memwrite", 32'(MemWrite), 32'd0);
    checkOutput("rst_adr", adr, 32'd0);
    checkOutput("rst_wrdata", wr_data, 32'd0);
    checkOutput("rst_checksum", checksum, 32'd0);
    rst_n = 1'b1;
    acc0 = accessCount;
    repeat (10) @(negedge clk);
    checkOutput("idle_access", 32'(accessCount - acc0), 32'd0);

    for (int i = 0; i < 4; i++) pokeWord(32'(4*i), 32'h1111_1111 * 32'(i + 1));
    for (int i = 0; i < 4; i++) pokeWord(32'h100 + 32'(4*i), 32'h0);
    modelCopy(32'h000, 32'h100, 4, expSum);
    done0 = doneCount;
    applyStimulus(32'h000, 32'h100, 11'd4);
    checkOutput("basic_busy", 32'(busy), 32'd1);
    checkOutput("basic_first_adr", adr, 32'h000);
    waitDone(cyc);
    checkOutput("basic_latency", 32'(cyc), 32'd8);
    checkOutput("basic_busy_at_done", 32'(busy), 32'd0);
    checkOutput("basic_checksum", checksum, 32'hAAAA_AAAA);
    checkOutput("basic_checksum_model", checksum, expSum);
    @(negedge clk);
    checkOutput("basic_done_once", 32'(doneCount - done0), 32'd1);
    for (int i = 0; i < 4; i++)
      checkOutput("basic_mem", memWord(12'(32'h100 + 32'(4*i))), 32'h1111_1111 * 32'(i + 1));
    checkWrites("basic");

    acc0 = accessCount;
    applyStimulus(32'h000, 32'h200, 11'd0);
    checkOutput("len0_done", 32'(done), 32'd1);
    @(negedge clk);
    checkOutput("len0_done_drop", 32'(done), 32'd0);
    checkOutput("len0_checksum", checksum, 32'd0);
    checkOutput("len0_access", 32'(accessCount - acc0), 32'd0);
    checkWrites("len0");

    pokeWord(32'h600, 32'hFFFF_FFFF);
    pokeWord(32'h604, 32'h0000_0002);
    modelCopy(32'h600, 32'h700, 2, expSum);
    applyStimulus(32'h600, 32'h700, 11'd2);
    waitDone(cyc);
    checkOutput("wrap_latency", 32'(cyc), 32'd4);
    checkOutput("wrap_checksum", checksum, 32'h0000_0001);
    checkWrites("wrap");

    for (int i = 0; i < 2; i++) pokeWord(32'h500 + 32'(4*i), 32'hA5A5_A5A5);
    modelCopy(32'h000, 32'h400, 4, expSum);
    done0 = doneCount;
    applyStimulus(32'h000, 32'h400, 11'd4);
    repeat (2) @(negedge clk);
    start = 1'b1; src_adr = 32'h040; dst_adr = 32'h500; len = 11'd2;
    @(negedge clk);
    start = 1'b0;
    waitDone(cyc);
    checkOutput("busy_start_checksum", checksum, expSum);
    repeat (6) @(negedge clk);
    checkOutput("busy_start_done_once", 32'(doneCount - done0), 32'd1);
    checkOutput("busy_start_untouched", memWord(12'h500), 32'hA5A5_A5A5);
    checkWrites("busy_start");

    pokeWord(32'h000, 32'hDEAD_BEEF);
    modelCopy(32'h000, 32'h004, 3, expSum);
    applyStimulus(32'h000, 32'h004, 11'd3);
    waitDone(cyc);
    checkOutput("overlap_latency", 32'(cyc), 32'd6);
    for (int i = 1; i < 4; i++)
      checkOutput("overlap_mem", memWord(12'(4*i)), 32'hDEAD_BEEF);
    checkOutput("overlap_checksum", checksum, expSum);
    checkWrites("overlap");

    for (int i = 0; i < 8; i++) pokeWord(32'h200 + 32'(4*i), 32'h0000_1000 + 32'(i));
    for (int i = 0; i < 8; i++) pokeWord(32'h300 + 32'(4*i), 32'hA5A5_A5A5);
    modelCopy(32'h200, 32'h300, 2, expSum);
    done0 = doneCount;
    applyStimulus(32'h200, 32'h300, 11'd8);
    repeat (4) @(negedge clk);
    checkOutput("abort_read_w2", 32'(MemRead), 32'd1);
    checkOutput("abort_adr_w2", adr, 32'h208);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_memread", 32'(MemRead), 32'd0);
    checkOutput("abort_memwrite", 32'(MemWrite), 32'd0);
    checkOutput("abort_adr", adr, 32'd0);
    checkOutput("abort_wrdata", wr_data, 32'd0);
    checkOutput("abort_checksum", checksum, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", 32'(doneCount - done0), 32'd0);
    for (int i = 0; i < 8; i++)
      checkOutput("abort_mem", memWord(12'(32'h300 + 32'(4*i))), modelWord(12'(32'h300 + 32'(4*i))));
    checkWrites("abort");

    checkOutput("never_both_enables", 32'(bothCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
